slc3_isdu_ctrl: RTL and testbench

Instruction sequencing and decode unit for the SLC-3 datapath. A Moore FSM fetches, decodes and executes one instruction at a time. It drives every load enable, bus gate, mux select and memory strobe the datapath consumes. Covers ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, plus a Run/Continue front-panel handshake.

---
 rtl/slc3_isdu_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_slc3_isdu_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_isdu_ctrl.sv
// SLC-3 instruction sequencing/decode unit: Moore FSM driving all datapath controls.
// Optional SLC3_SINGLE_STEP_EN: park in StepWait after each instruction until Continue pulses.
module slc3_isdu_ctrl #(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S00, S22,
        S12, S04, S21, S06, S07,
        S25, S27, S23, S16,
        PAUSE_IR1, PAUSE_IR2,
        STEP_WAIT, STEP_WAIT2
    } state_t;

`ifdef SLC3_SINGLE_STEP_EN
    localparam state_t DONE_ST = STEP_WAIT;
`else
    localparam state_t DONE_ST = S18;
`endif

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT_CYCLES - 1);

    state_t     state;
    state_t     next;
    logic [2:0] wait_cnt;
    logic       mem_state;
    logic       mem_last;
    logic       unused_ir11;

    assign unused_ir11 = IR_11;

    assign mem_state = (state == S33) || (state == S25) || (state == S16);
    assign mem_last  = (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= HALTED;
            wait_cnt <= 3'd0;
        end else begin
            state <= next;
            if (mem_state && !mem_last)
                wait_cnt <= wait_cnt + 3'd1;
            else
                wait_cnt <= 3'd0;
        end
    end

    always_comb begin
        next       = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state)
            HALTED: if (Run) next = S18;
            S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                next   = S33;
            end
            S33: begin
                Mem_OE = 1'b1;
                LD_MDR = mem_last;
                if (mem_last) next = S35;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                next    = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: next = S01;
                    4'b0101: next = S05;
                    4'b1001: next = S09;
                    4'b0000: next = S00;
                    4'b1100: next = S12;
                    4'b0100: next = S04;
                    4'b0110: next = S06;
                    4'b0111: next = S07;
                    4'b1101: next = PAUSE_IR1;
                    default: next = DONE_ST;
                endcase
            end
            S01, S05: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state == S05) ? 2'b01 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                next    = DONE_ST;
            end
            S09: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                next    = DONE_ST;
            end
            S00: next = BEN ? S22 : DONE_ST;
            S22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                next     = DONE_ST;
            end
            S12: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                next     = DONE_ST;
            end
            S04: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
                next   = S21;
            end
            S21: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                next     = DONE_ST;
            end
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                next       = (state == S06) ? S25 : S23;
            end
            S25: begin
                Mem_OE = 1'b1;
                LD_MDR = mem_last;
                if (mem_last) next = S27;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                next    = DONE_ST;
            end
            S23: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                next    = S16;
            end
            S16: begin
                Mem_WE = 1'b1;
                if (mem_last) next = DONE_ST;
            end
            PAUSE_IR1: begin
                LD_LED = 1'b1;
                if (Continue) next = PAUSE_IR2;
            end
            PAUSE_IR2: if (!Continue) next = DONE_ST;
`ifdef SLC3_SINGLE_STEP_EN
            STEP_WAIT:  if (Continue) next = STEP_WAIT2;
            STEP_WAIT2: if (!Continue) next = S18;
`endif
            default: next = HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_isdu_ctrl.sv
// Directed bench for slc3_isdu_ctrl: per-cycle control word checks per instruction.
module tb_slc3_isdu_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_OE, Mem_WE;

    int pass_cnt = 0;
    int total    = 0;

    slc3_isdu_ctrl #(.MEM_WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [23:0] outs;
    assign outs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                   GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX,
                   SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    localparam logic [23:0] B_LD_MAR  = 24'd1 << 23;
    localparam logic [23:0] B_LD_MDR  = 24'd1 << 22;
    localparam logic [23:0] B_LD_IR   = 24'd1 << 21;
    localparam logic [23:0] B_LD_BEN  = 24'd1 << 20;
    localparam logic [23:0] B_LD_CC   = 24'd1 << 19;
    localparam logic [23:0] B_LD_REG  = 24'd1 << 18;
    localparam logic [23:0] B_LD_PC   = 24'd1 << 17;
    localparam logic [23:0] B_LD_LED  = 24'd1 << 16;
    localparam logic [23:0] B_GPC     = 24'd1 << 15;
    localparam logic [23:0] B_GMDR    = 24'd1 << 14;
    localparam logic [23:0] B_GALU    = 24'd1 << 13;
    localparam logic [23:0] B_GMARMUX = 24'd1 << 12;
    localparam logic [23:0] B_PC_ADR  = 24'd2 << 10;
    localparam logic [23:0] B_DRMUX   = 24'd1 << 9;
    localparam logic [23:0] B_SR1     = 24'd1 << 8;
    localparam logic [23:0] B_SR2     = 24'd1 << 7;
    localparam logic [23:0] B_A1      = 24'd1 << 6;
    localparam logic [23:0] B_A2_01   = 24'd1 << 4;
    localparam logic [23:0] B_A2_10   = 24'd2 << 4;
    localparam logic [23:0] B_A2_11   = 24'd3 << 4;
    localparam logic [23:0] B_ALU_AND = 24'd1 << 2;
    localparam logic [23:0] B_ALU_NOT = 24'd2 << 2;
    localparam logic [23:0] B_ALU_PA  = 24'd3 << 2;
    localparam logic [23:0] B_OE      = 24'd1 << 1;
    localparam logic [23:0] B_WE      = 24'd1;

    localparam logic [23:0] E_ZERO = 24'd0;
    localparam logic [23:0] E_S18  = B_LD_MAR | B_LD_PC | B_GPC;
    localparam logic [23:0] E_RD1  = B_OE;
    localparam logic [23:0] E_RD2  = B_OE | B_LD_MDR;
    localparam logic [23:0] E_S35  = B_GMDR | B_LD_IR;
    localparam logic [23:0] E_S32  = B_LD_BEN;
    localparam logic [23:0] E_S01  = B_SR1 | B_SR2 | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S05  = B_SR1 | B_ALU_AND | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S09  = B_SR1 | B_ALU_NOT | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S22  = B_A2_10 | B_PC_ADR | B_LD_PC;
    localparam logic [23:0] E_S12  = B_SR1 | B_A1 | B_PC_ADR | B_LD_PC;
    localparam logic [23:0] E_S04  = B_GPC | B_DRMUX | B_LD_REG;
    localparam logic [23:0] E_S21  = B_A2_11 | B_PC_ADR | B_LD_PC;
    localparam logic [23:0] E_S67  = B_SR1 | B_A1 | B_A2_01 | B_GMARMUX | B_LD_MAR;
    localparam logic [23:0] E_S27  = B_GMDR | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S23  = B_ALU_PA | B_GALU | B_LD_MDR;

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0; Run = 1'b1; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        step(); step();
        total++;
        if (outs !== E_ZERO) $display("FAIL reset_hold got %h exp %h", outs, E_ZERO);
        else pass_cnt++;
        Run = 1'b0; Reset = 1'b1;
        step(); step();
        total++;
        if (outs !== E_ZERO) $display("FAIL halted_idle got %h exp %h", outs, E_ZERO);
        else pass_cnt++;
        Run = 1'b1;
        step();
        total++;
        if (outs !== E_S18) $display("FAIL first_fetch got %h exp %h", outs, E_S18);
        else pass_cnt++;
        Run = 1'b0;
    endtask

    task automatic test_add;
        logic [23:0] seq [$];
        Opcode = 4'b0001; IR_5 = 1'b1;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S01, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL add c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_and_not;
        logic [23:0] seq [$];
        Opcode = 4'b0101; IR_5 = 1'b0;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S05, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL and c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        Opcode = 4'b1001;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S09, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL not c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_br;
        logic [23:0] seq [$];
        Opcode = 4'b0000; BEN = 1'b0;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_ZERO, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL br_nt c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        BEN = 1'b1;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_ZERO, E_S22, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL br_t c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        BEN = 1'b0;
    endtask

    task automatic test_jmp_jsr;
        logic [23:0] seq [$];
        Opcode = 4'b1100;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S12, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL jmp c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        Opcode = 4'b0100; IR_11 = 1'b1;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S04, E_S21, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL jsr c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ldr_str;
        logic [23:0] seq [$];
        Opcode = 4'b0110;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S67, E_RD1, E_RD2, E_S27, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL ldr c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        Opcode = 4'b0111;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S67, E_S23, B_WE, B_WE, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL str c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_nop;
        logic [23:0] seq [$];
        Opcode = 4'b1111;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S18};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL nop c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_pause;
        logic [23:0] seq [$];
        Opcode = 4'b1101; Continue = 1'b0;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, B_LD_LED, B_LD_LED, B_LD_LED};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL pause c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        Continue = 1'b1;
        step(); step();
        total++;
        if (outs !== E_ZERO) $display("FAIL pause2_hold got %h exp %h", outs, E_ZERO);
        else pass_cnt++;
        Continue = 1'b0;
        step();
        total++;
        if (outs !== E_S18) $display("FAIL pause_resume got %h exp %h", outs, E_S18);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [23:0] seq [$];
        Opcode = 4'b0111;
        seq = '{E_RD1, E_RD2, E_S35, E_S32, E_S67, E_S23, B_WE};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL rmid c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        Run = 1'b0;
        #2 Reset = 1'b0;
        #1;
        total++;
        if (outs !== E_ZERO) $display("FAIL async_abort got %h exp %h", outs, E_ZERO);
        else pass_cnt++;
        step();
        Reset = 1'b1;
        step(); step(); step();
        total++;
        if (outs !== E_ZERO) $display("FAIL no_refetch got %h exp %h", outs, E_ZERO);
        else pass_cnt++;
        Run = 1'b1;
        seq = '{E_S18, E_RD1, E_RD2};
        for (int i = 0; i < seq.size(); i++) begin
            step(); total++;
            if (outs !== seq[i]) $display("FAIL restart c%0d got %h exp %h", i, outs, seq[i]);
            else pass_cnt++;
        end
        Run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_and_not();
        test_br();
        test_jmp_jsr();
        test_ldr_str();
        test_nop();
        test_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
